// File: rtl/row_drain.sv
// rtl/row_drain.sv - snapshot one systolic row's result bus and stream it out word by word
module row_drain #(
  parameter int N = 8,
  parameter int M = N,
  parameter int S = 8,
  localparam int IW = $clog2(S)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap,
  input  logic [S*M-1:0]    Data_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [M-1:0]      out_data,
  output logic [IW-1:0]     out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [IW-1:0] LAST = IW'(S - 1);

  logic [0:0]     state;
  logic [S*M-1:0] shadow;
  logic [M-1:0]   words [S];
  logic [IW-1:0]  nidx;
  logic           final_hs;
  logic           accept;

  // Unpack the snapshot so PE k is words[k] (PE 0 lives in the top slice)
  always_comb begin
    for (int k = 0; k < S; k++) begin
      words[k] = shadow[(S-1-k)*M +: M];
    end
  end

  // Next index and capture acceptance; a cap on the final handshake edge chains captures
  always_comb begin
    nidx     = out_idx + IW'(1);
    final_hs = (state == SEND) && out_valid && out_ready && (out_idx == LAST);
    accept   = cap && ((state == IDLE) || final_hs);
  end

  // Two-state drain FSM with fully registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shadow    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      ovf  <= 1'b0;
      if ((state == SEND) && out_valid && out_ready) begin
        if (out_idx == LAST) begin
          done      <= 1'b1;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end else begin
          out_idx  <= nidx;
          out_data <= words[nidx];
          out_last <= (nidx == LAST);
        end
      end
      // An accepted capture overrides the end-of-stream teardown above
      if (accept) begin
        shadow    <= Data_in;
        out_idx   <= '0;
        out_data  <= Data_in[S*M-1 -: M];
        out_last  <= 1'b0;
        out_valid <= 1'b1;
        busy      <= 1'b1;
        state     <= SEND;
      end else if (cap && (state == SEND)) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_row_drain.sv
// tb/tb_row_drain.sv - directed self-checking bench for row_drain
module tb_row_drain;

  localparam int N = 8;
  localparam int M = 8;
  localparam int S = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cap = 1'b0;
  logic [63:0]  Data_in = '0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [7:0]   out_data;
  logic [2:0]   out_idx;
  logic         out_last;
  logic         busy;
  logic         done;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  row_drain #(.N(N), .M(M), .S(S)) dut (
    .clk(clk), .rst(rst), .cap(cap), .Data_in(Data_in),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy),
    .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] build(input logic [7:0] base);
    logic [63:0] d;
    for (int k = 0; k < 8; k++) d[(7-k)*8 +: 8] = base + 8'(k);
    return d;
  endfunction

  task automatic chk_word(input string tag, input logic [7:0] data, input logic [2:0] idx);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(data));
    chk({tag, "_idx"}, 32'(out_idx), 32'(idx));
    chk({tag, "_last"}, 32'(out_last), 32'(idx == 3'd7));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic chk_end(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_valid0"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy0"}, 32'(busy), 32'd0);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [3:0] pat;
    int e;
    int cyc;
    pat = 4'b1001;

    // Reset state
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Basic drain with out_ready held high
    Data_in = build(8'h10);
    out_ready = 1'b1;
    cap = 1'b1;
    tick();
    cap = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk_word("basic", 8'h10 + 8'(k), 3'(k));
      chk("basic_nodone", 32'(done), 32'd0);
      tick();
    end
    chk_end("basic");

    // Backpressure: ready pattern 1,0,0,1
    cap = 1'b1;
    tick();
    cap = 1'b0;
    e = 0;
    cyc = 0;
    while (e < 8 && cyc < 100) begin
      out_ready = pat[3 - (cyc % 4)];
      chk_word("bp", 8'h10 + 8'(e), 3'(e));
      chk("bp_nodone", 32'(done), 32'd0);
      tick();
      if (out_ready) e++;
      cyc++;
    end
    chk("bp_count", 32'(e), 32'd8);
    chk_end("bp");

    // Overflow: rejected cap at idx 3, then Data_in scrambled
    out_ready = 1'b1;
    cap = 1'b1;
    tick();
    cap = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk_word("ovf", 8'h10 + 8'(k), 3'(k));
      chk("ovf_pulse", 32'(ovf), 32'(k == 4));
      if (k == 3) cap = 1'b1;
      tick();
      cap = 1'b0;
      Data_in = {8{8'hFF}};
    end
    chk_end("ovf");

    // Back-to-back capture on the final handshake edge
    Data_in = build(8'h10);
    cap = 1'b1;
    tick();
    cap = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk_word("b2b_a", 8'h10 + 8'(k), 3'(k));
      if (k == 7) begin
        cap = 1'b1;
        Data_in = build(8'h20);
      end
      tick();
    end
    cap = 1'b0;
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_ovf", 32'(ovf), 32'd0);
    for (int k = 0; k < 8; k++) begin
      chk_word("b2b_b", 8'h20 + 8'(k), 3'(k));
      tick();
    end
    chk_end("b2b");

    // Reset mid-transfer at idx 5
    Data_in = build(8'h10);
    cap = 1'b1;
    tick();
    cap = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk_word("mid", 8'h15, 3'd5);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_idx", 32'(out_idx), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    tick();
    chk("arst_nodone", 32'(done), 32'd0);
    rst = 1'b1;
    tick();
    chk("post_nodone", 32'(done), 32'd0);
    chk("post_idle", 32'(out_valid), 32'd0);
    Data_in = build(8'h30);
    cap = 1'b1;
    tick();
    cap = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk_word("restart", 8'h30 + 8'(k), 3'(k));
      tick();
    end
    chk_end("restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/row_drain.md
Name: row_drain

Overview:
- Result reader at the output end of one systolic row: snapshots the row's packed S-word result bus and streams the words out one per handshake.
- Sits between a row's Data output and the result collector / output memory.
- Decouples row timing from downstream backpressure; the row may start its next computation as soon as the capture is taken.

Parameters:
- N, 8, input operand width; not used internally, kept for parameter passing with the row.
- M, N, width of one result word.
- S, 8, number of PEs per row, i.e. words per capture; S >= 2.
- IW, derived as $clog2(S) (localparam), width of the word index.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cap  in  1  capture request, single-cycle, sampled on the clk edge.
- Data_in  in  S*M  packed row results; PE k occupies Data_in[(S-k)*M-1:(S-k-1)*M], so PE 0 is the top slice.
- out_ready  in  1  downstream ready.
- out_valid  out  1  out_data, out_idx and out_last are valid.
- out_data  out  M  current result word.
- out_idx  out  IW  PE index of out_data, 0..S-1.
- out_last  out  1  high with the word for PE S-1.
- busy  out  1  a capture is held or being streamed.
- done  out  1  one-cycle pulse after the final word's handshake.
- ovf  out  1  one-cycle pulse when cap is rejected.

Behaviour:
- Reset (rst low, asynchronous):
  - out_valid, out_last, busy, done and ovf go to 0.
  - out_idx and out_data go to 0.
  - The shadow register is cleared and the FSM goes to IDLE.
  - Reset during streaming abandons the transfer: no done pulse, and the next accepted cap restarts at idx 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- FSM has two states, IDLE and SEND.
- IDLE:
  - cap=1 latches all of Data_in into an S*M shadow register, sets idx=0 and moves to SEND.
  - out_valid rises the cycle after cap, with out_data = PE 0 word: one-cycle latency.
  - busy=1 from the same edge.
- SEND:
  - out_data and out_idx are held stable while out_valid=1 and out_ready=0.
  - Handshake happens on an edge where out_valid and out_ready are both 1.
  - Handshake with idx<S-1: idx increments, out_data takes shadow word idx+1, out_valid stays 1.
  - out_last = (idx==S-1) while valid.
  - Handshake with idx==S-1: out_valid drops, busy drops, done pulses 1 for one cycle, FSM returns to IDLE.
  - Maximum throughput is one word per cycle; S words take S cycles with out_ready held at 1.
- cap during SEND, other than on the final-handshake edge:
  - The capture is ignored and the shadow register is unchanged.
  - ovf pulses for one cycle on the following cycle.
- cap on the same edge as the final handshake (back-to-back):
  - The capture is accepted: the new Data_in is latched and idx resets to 0.
  - out_valid stays 1 with no bubble and busy stays 1.
  - done still pulses for the completed capture; ovf stays 0.
- Data_in is sampled only on accepted cap edges; later changes do not affect the stream.
- out_ready is ignored while out_valid=0.
- out_idx wraps only through the capture restart, never by increment past S-1.

Test Plan:
- Basic drain: reset, S=8, M=8, Data_in word k = 8'h10+k, cap pulse, out_ready=1 -> out_valid from the next cycle for 8 cycles with out_data 10..17 and out_idx 0..7; out_last only with 17; done one cycle after the 17 handshake; busy 8 cycles.
- Backpressure: same data, out_ready pattern 1,0,0,1 repeating -> each word held stable across the stall cycles; sequence 10..17 with no drops or duplicates; done only after the 17 handshake.
- Overflow and snapshot: cap at idx=3, then Data_in changed to all 8'hFF -> ovf pulse one cycle later; stream continues 13..17 unchanged; no FF values appear.
- Back-to-back: second cap (word k = 8'h20+k) coincident with the 17 handshake -> done=1 and ovf=0; next cycle out_data=20 and out_idx=0 with out_valid never deasserting; 20..27 follow.
- Reset mid-transfer: rst low at idx=5 -> all outputs 0 immediately, asynchronously; no done pulse; after release, cap with word k = 8'h30+k streams 30..37 starting from idx 0.
